chip_recv_deframer: RTL

Receive-side deframer for one mesh port of the inter-chip link. It accepts CHIPDATA_WIDTH-bit words with a valid/ready handshake and per-word parity from the off-chip pins. It reassembles them into one packet of FW flit bits plus connect-id bits and delivers that packet to chip_connection as a data_in_wr / data_in write. It is the inverse of the send-side serializer in chip_interface: one instance per port (E/N/W/S) between the recv_data_* pins and chip_connection.

---
 rtl/chip_recv_deframer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/chip_recv_deframer.sv
// Receive-side deframer: collects NWORDS parity-protected link words into one
// packet (connect id above the flit) and writes it to chip_connection.
module chip_recv_deframer #(
  parameter  int FW             = 59,
  parameter  int CONNECT        = 2,
  parameter  int CHIPDATA_WIDTH = 16,
  localparam int CIW            = (CONNECT > 1) ? $clog2(CONNECT) : 1,
  localparam int PW             = FW + CIW,
  localparam int NWORDS         = (PW + CHIPDATA_WIDTH - 1) / CHIPDATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHIPDATA_WIDTH-1:0] recv_data_in,
  input  logic                      recv_data_valid,
  input  logic                      recv_data_par,
  output logic                      recv_data_ready,
  output logic                      recv_data_err,
  output logic [PW-1:0]             data_in,
  output logic                      data_in_wr,
  input  logic [CONNECT-1:0]        connect_available,
  output logic [7:0]                err_cnt
);

  localparam int CW   = CHIPDATA_WIDTH;
  localparam int WB   = NWORDS * CW;
  localparam int CNTW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic {S_COLLECT, S_HOLD} state_e;

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic            bad_q;
  logic [WB-1:0]   shreg_q;
  logic [PW-1:0]   data_q;
  logic            ready_q;
  logic            err_q;
  logic [7:0]      err_cnt_q;

  logic            accept;
  logic            last_word;
  logic            par_bad;
  logic [WB-1:0]   shreg_d;
  logic [CIW-1:0]  id_d;
  logic            id_ok;
  logic            drop_now;
  logic [CIW-1:0]  hold_id;
  logic            hold_avail;
  logic            hold_fire;

  // Words shift in from the top so word 0 ends up in the LSBs after NWORDS shifts.
  assign accept    = recv_data_valid && ready_q;
  assign last_word = (cnt_q == CNTW'(NWORDS - 1));
  assign par_bad   = (^recv_data_in) != recv_data_par;
  assign shreg_d   = {recv_data_in, shreg_q[WB-1:CW]};
  assign id_d      = shreg_d[PW-1:FW];
  assign hold_id   = shreg_q[PW-1:FW];

  always_comb begin
    id_ok      = 1'b0;
    hold_avail = 1'b0;
    for (int i = 0; i < CONNECT; i++) begin
      if (id_d == CIW'(i))    id_ok      = 1'b1;
      if (hold_id == CIW'(i)) hold_avail = connect_available[i];
    end
  end

  assign drop_now  = bad_q || par_bad || !id_ok;
  assign hold_fire = (state_q == S_HOLD) && hold_avail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_COLLECT;
      cnt_q     <= '0;
      bad_q     <= 1'b0;
      shreg_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= accept && (par_bad || (last_word && !id_ok));
      case (state_q)
        S_COLLECT: begin
          ready_q <= 1'b1;
          if (accept) begin
            shreg_q <= shreg_d;
            if (last_word) begin
              cnt_q <= '0;
              bad_q <= 1'b0;
              if (drop_now) begin
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              end else begin
                state_q <= S_HOLD;
                ready_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
              bad_q <= bad_q || par_bad;
            end
          end
        end
        S_HOLD: begin
          // Strobe is combinational so it appears in the first cycle the target frees up.
          if (hold_avail) begin
            state_q <= S_COLLECT;
            ready_q <= 1'b1;
            data_q  <= shreg_q[PW-1:0];
          end
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end

  assign recv_data_ready = ready_q;
  assign recv_data_err   = err_q;
  assign data_in_wr      = hold_fire;
  assign data_in         = hold_fire ? shreg_q[PW-1:0] : data_q;
  assign err_cnt         = err_cnt_q;

endmodule
